// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter.
//   mem_cmd_e   : requester command encodings (2'b11 is unused and means no-op)
//   arb_state_e : arbiter FSM states
//   is_active() : true when a command needs the RAM port
package mem_arb_pkg;

  typedef enum logic [1:0] {
    M_NOP   = 2'b00,
    M_WRITE = 2'b01,
    M_READ  = 2'b10
  } mem_cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_e;

  function automatic logic is_active(input logic [1:0] cmd);
    return (cmd == M_READ) || (cmd == M_WRITE);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a single-port RAM.
//   r0_* / r1_* : requester command/address/write data in; grant, read data,
//                 read-valid out
//   mem_*       : shared RAM port (write strobe, address, write data out;
//                 read data in)
// slave  : arbiter side
// master : requesters + RAM side (testbench / top level)
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [1:0]        r0_cmd,    r1_cmd;
  logic [ADDR_W-1:0] r0_addr,   r1_addr;
  logic [DATA_W-1:0] r0_wdata,  r1_wdata;
  logic              r0_gnt,    r1_gnt;
  logic [DATA_W-1:0] r0_rdata,  r1_rdata;
  logic              r0_rvalid, r1_rvalid;

  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  r0_cmd, r1_cmd, r0_addr, r1_addr, r0_wdata, r1_wdata, mem_rdata,
    output r0_gnt, r1_gnt, r0_rdata, r1_rdata, r0_rvalid, r1_rvalid,
           mem_write, mem_addr, mem_wdata
  );

  modport master (
    output r0_cmd, r1_cmd, r0_addr, r1_addr, r0_wdata, r1_wdata, mem_rdata,
    input  r0_gnt, r1_gnt, r0_rdata, r1_rdata, r0_rvalid, r1_rvalid,
           mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one shared single-port RAM.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : mem_arbiter_if.slave (requester handshakes + RAM port)
// Grants are combinational in the request cycle. An owner keeps the port for
// up to MAX_HOLD consecutive cycles while the other side waits, then the port
// is handed over. Read data is captured at the rising edge that ends the grant
// cycle (the RAM presents it on the falling edge), so rvalid follows one
// cycle later.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  mem_arbiter_if.slave bus
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  arb_state_e        state_q, state_d;
  logic [HW-1:0]     hold_q,  hold_d;
  logic              last_q,  last_d;   // 0: r0 served last, 1: r1 served last
  logic              act0, act1, pick;
  logic              gnt0, gnt1, any_gnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              rvalid0_q, rvalid1_q;
  logic              rd0, rd1;

  assign act0 = is_active(bus.r0_cmd);
  assign act1 = is_active(bus.r1_cmd);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    pick    = 1'b0;
    if (!reset) begin
      case (state_q)
        OWN0:
          if (act0) begin
            if (!act1 || hold_q < HOLD_MAX) begin
              gnt0 = 1'b1;
              if (hold_q < HOLD_MAX) hold_d = hold_q + HOLD_ONE;
            end else begin
              gnt1    = 1'b1;
              state_d = OWN1;
              hold_d  = HOLD_ONE;
            end
          end else begin
            pick = 1'b1;
          end
        OWN1:
          if (act1) begin
            if (!act0 || hold_q < HOLD_MAX) begin
              gnt1 = 1'b1;
              if (hold_q < HOLD_MAX) hold_d = hold_q + HOLD_ONE;
            end else begin
              gnt0    = 1'b1;
              state_d = OWN0;
              hold_d  = HOLD_ONE;
            end
          end else begin
            pick = 1'b1;
          end
        default: pick = 1'b1;
      endcase

      // Fresh arbitration: a tie goes to whoever was not served last.
      if (pick) begin
        if (act0 && (!act1 || last_q)) begin
          gnt0    = 1'b1;
          state_d = OWN0;
          hold_d  = HOLD_ONE;
        end else if (act1) begin
          gnt1    = 1'b1;
          state_d = OWN1;
          hold_d  = HOLD_ONE;
        end else begin
          state_d = IDLE;
          hold_d  = '0;
        end
      end

      if (gnt0) last_d = 1'b0;
      if (gnt1) last_d = 1'b1;
    end
  end

  assign any_gnt = gnt0 | gnt1;
  assign rd0     = gnt0 && (bus.r0_cmd == M_READ);
  assign rd1     = gnt1 && (bus.r1_cmd == M_READ);

  assign bus.r0_gnt    = gnt0;
  assign bus.r1_gnt    = gnt1;
  assign bus.mem_write = (gnt0 && bus.r0_cmd == M_WRITE) ||
                         (gnt1 && bus.r1_cmd == M_WRITE);
  // Idle port keeps the last granted address/data to avoid needless toggling.
  assign bus.mem_addr  = gnt1 ? bus.r1_addr  : (gnt0 ? bus.r0_addr  : addr_q);
  assign bus.mem_wdata = gnt1 ? bus.r1_wdata : (gnt0 ? bus.r0_wdata : wdata_q);

  assign bus.r0_rdata  = rdata0_q;
  assign bus.r1_rdata  = rdata1_q;
  // A read granted just before reset must not surface its pulse in the reset
  // cycle, so the valid is masked by reset itself.
  assign bus.r0_rvalid = rvalid0_q & ~reset;
  assign bus.r1_rvalid = rvalid1_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      last_q    <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
      if (any_gnt) begin
        addr_q  <= bus.mem_addr;
        wdata_q <= bus.mem_wdata;
      end
      rvalid0_q <= rd0;
      rvalid1_q <= rd1;
      if (rd0) rdata0_q <= bus.mem_rdata;
      if (rd1) rdata1_q <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM
// (read data registered on the falling edge, writes on the rising edge).
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] ram [256];

  mem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  mem_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) bus.mem_rdata <= ram[bus.mem_addr];
  always @(posedge clk) if (bus.mem_write) ram[bus.mem_addr] <= bus.mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] c0, input logic [7:0] a0, input logic [15:0] w0,
                       input logic [1:0] c1, input logic [7:0] a1, input logic [15:0] w1);
    bus.r0_cmd = c0; bus.r0_addr = a0; bus.r0_wdata = w0;
    bus.r1_cmd = c1; bus.r1_addr = a1; bus.r1_wdata = w1;
  endtask

  initial begin
    int  k;
    logic e0, e1, prev_e0;
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    ram[8'h05] = 16'hABCD;
    ram[8'h20] = 16'h1234;
    ram[8'h30] = 16'h3333;
    for (int i = 0; i < 10; i++) ram[8'h40 + i] = 16'h4000 + 16'(i);

    // Reset with r0 already requesting: nothing may be granted.
    reset = 1'b1;
    drive(M_READ, 8'h05, 16'h0, M_NOP, 8'h0, 16'h0);
    tick; tick;
    #3;
    chk("rst_gnt0",   32'(bus.r0_gnt),    32'd0);
    chk("rst_mwr",    32'(bus.mem_write), 32'd0);
    chk("rst_rv0",    32'(bus.r0_rvalid), 32'd0);
    chk("rst_rdata0", 32'(bus.r0_rdata),  32'h0);
    chk("rst_maddr",  32'(bus.mem_addr),  32'h0);
    chk("rst_mwdata", 32'(bus.mem_wdata), 32'h0);

    // Single read by r0.
    tick; reset = 1'b0; #3;
    chk("rd_gnt0",  32'(bus.r0_gnt),    32'd1);
    chk("rd_gnt1",  32'(bus.r1_gnt),    32'd0);
    chk("rd_maddr", 32'(bus.mem_addr),  32'h05);
    chk("rd_mwr",   32'(bus.mem_write), 32'd0);
    tick; drive(M_NOP, 8'h0, 16'h0, M_NOP, 8'h0, 16'h0); #3;
    chk("rd_rv0",    32'(bus.r0_rvalid), 32'd1);
    chk("rd_rdata0", 32'(bus.r0_rdata),  32'hABCD);
    chk("rd_rv1",    32'(bus.r1_rvalid), 32'd0);
    chk("rd_rdata1", 32'(bus.r1_rdata),  32'h0);
    chk("rd_hold",   32'(bus.mem_addr),  32'h05);
    tick; #3;
    chk("rd_rv0_off", 32'(bus.r0_rvalid), 32'd0);

    // Simultaneous writes straight out of reset: r0 first, then r1.
    tick; reset = 1'b1; #3;
    tick; reset = 1'b0;
    drive(M_WRITE, 8'h10, 16'h1111, M_WRITE, 8'h11, 16'h2222); #3;
    chk("ww_gnt0",  32'(bus.r0_gnt),    32'd1);
    chk("ww_gnt1",  32'(bus.r1_gnt),    32'd0);
    chk("ww_mwr0",  32'(bus.mem_write), 32'd1);
    chk("ww_addr0", 32'(bus.mem_addr),  32'h10);
    chk("ww_data0", 32'(bus.mem_wdata), 32'h1111);
    tick; drive(M_NOP, 8'h0, 16'h0, M_WRITE, 8'h11, 16'h2222); #3;
    chk("ww_gnt1b", 32'(bus.r1_gnt),    32'd1);
    chk("ww_gnt0b", 32'(bus.r0_gnt),    32'd0);
    chk("ww_addr1", 32'(bus.mem_addr),  32'h11);
    chk("ww_data1", 32'(bus.mem_wdata), 32'h2222);
    tick; drive(M_NOP, 8'h0, 16'h0, M_NOP, 8'h0, 16'h0); #3;
    chk("ww_ram10",  32'(ram[8'h10]),    32'h1111);
    chk("ww_ram11",  32'(ram[8'h11]),    32'h2222);
    chk("ww_idle_w", 32'(bus.mem_write), 32'd0);
    chk("ww_idle_a", 32'(bus.mem_addr),  32'h11);
    chk("ww_idle_d", 32'(bus.mem_wdata), 32'h2222);

    // r0 streams 10 reads, r1 waits with one read: 4 x r0, 1 x r1, r0 resumes.
    k = 0;
    prev_e0 = 1'b0;
    for (int c = 0; c < 11; c++) begin
      e0 = (c != 4);
      e1 = (c == 4);
      tick;
      drive(M_READ, 8'h40 + 8'(k), 16'h0,
            (c <= 4) ? M_READ : M_NOP, 8'h30, 16'h0);
      #3;
      chk($sformatf("str_gnt0_%0d", c), 32'(bus.r0_gnt), 32'(e0));
      chk($sformatf("str_gnt1_%0d", c), 32'(bus.r1_gnt), 32'(e1));
      chk($sformatf("str_rv0_%0d", c),  32'(bus.r0_rvalid), 32'(prev_e0));
      if (prev_e0)
        chk($sformatf("str_rd0_%0d", c), 32'(bus.r0_rdata), 32'h4000 + 32'(k - 1));
      chk($sformatf("str_rv1_%0d", c),  32'(bus.r1_rvalid), 32'(c == 5));
      if (c == 5)
        chk("str_rd1", 32'(bus.r1_rdata), 32'h3333);
      if (e0) k++;
      prev_e0 = e0;
    end
    tick; drive(M_NOP, 8'h0, 16'h0, M_NOP, 8'h0, 16'h0); #3;
    chk("str_last_rv0", 32'(bus.r0_rvalid), 32'd1);
    chk("str_last_rd0", 32'(bus.r0_rdata),  32'h4009);
    chk("str_last_rv1", 32'(bus.r1_rvalid), 32'd0);

    // r1: read, write, read of 0x20.
    tick; drive(M_NOP, 8'h0, 16'h0, M_READ, 8'h20, 16'h0); #3;
    chk("rwr_gnt1a", 32'(bus.r1_gnt),   32'd1);
    chk("rwr_addr",  32'(bus.mem_addr), 32'h20);
    tick; drive(M_NOP, 8'h0, 16'h0, M_WRITE, 8'h20, 16'h5A5A); #3;
    chk("rwr_gnt1b", 32'(bus.r1_gnt),    32'd1);
    chk("rwr_mwr",   32'(bus.mem_write), 32'd1);
    chk("rwr_rv1a",  32'(bus.r1_rvalid), 32'd1);
    chk("rwr_rd1a",  32'(bus.r1_rdata),  32'h1234);
    tick; drive(M_NOP, 8'h0, 16'h0, M_READ, 8'h20, 16'h0); #3;
    chk("rwr_gnt1c", 32'(bus.r1_gnt),    32'd1);
    chk("rwr_rv1b",  32'(bus.r1_rvalid), 32'd0);
    tick; drive(M_NOP, 8'h0, 16'h0, M_NOP, 8'h0, 16'h0); #3;
    chk("rwr_rv1c",  32'(bus.r1_rvalid), 32'd1);
    chk("rwr_rd1c",  32'(bus.r1_rdata),  32'h5A5A);
    chk("rwr_rv0",   32'(bus.r0_rvalid), 32'd0);
    chk("rwr_rd0",   32'(bus.r0_rdata),  32'h4009);

    // Command 11 is a no-op.
    tick; drive(2'b11, 8'h77, 16'hFFFF, M_NOP, 8'h0, 16'h0); #3;
    chk("c11_gnt0", 32'(bus.r0_gnt),    32'd0);
    chk("c11_gnt1", 32'(bus.r1_gnt),    32'd0);
    chk("c11_mwr",  32'(bus.mem_write), 32'd0);
    chk("c11_addr", 32'(bus.mem_addr),  32'h20);

    // Reset right after an r0 read grant kills the pending rvalid.
    tick; drive(M_READ, 8'h05, 16'h0, M_NOP, 8'h0, 16'h0); #3;
    chk("rr_gnt0", 32'(bus.r0_gnt), 32'd1);
    tick; reset = 1'b1; drive(M_NOP, 8'h0, 16'h0, M_NOP, 8'h0, 16'h0); #3;
    chk("rr_rv0_rst",  32'(bus.r0_rvalid), 32'd0);
    chk("rr_gnt0_rst", 32'(bus.r0_gnt),    32'd0);
    tick; reset = 1'b0; #3;
    chk("rr_rv0",    32'(bus.r0_rvalid), 32'd0);
    chk("rr_rd0",    32'(bus.r0_rdata),  32'h0);
    chk("rr_rd1",    32'(bus.r1_rdata),  32'h0);
    chk("rr_maddr",  32'(bus.mem_addr),  32'h0);
    chk("rr_mwdata", 32'(bus.mem_wdata), 32'h0);
    tick; drive(M_READ, 8'h05, 16'h0, M_READ, 8'h20, 16'h0); #3;
    chk("rr_tie_g0", 32'(bus.r0_gnt), 32'd1);
    chk("rr_tie_g1", 32'(bus.r1_gnt), 32'd0);
    tick; drive(M_NOP, 8'h0, 16'h0, M_READ, 8'h20, 16'h0); #3;
    chk("rr_next_g1", 32'(bus.r1_gnt),    32'd1);
    chk("rr_next_rv", 32'(bus.r0_rvalid), 32'd1);
    tick; drive(M_NOP, 8'h0, 16'h0, M_NOP, 8'h0, 16'h0); #3;
    chk("rr_end_rv1", 32'(bus.r1_rvalid), 32'd1);
    chk("rr_end_rd1", 32'(bus.r1_rdata),  32'h5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory word-address width.
REQ-002 Parameter DATA_W, default 16, memory data width.
REQ-003 Parameter MAX_HOLD, default 4, maximum consecutive grant cycles to one owner while the other requester waits.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 r0_cmd / r1_cmd  input  2 each  command: M_NOP=00, M_READ=10, M_WRITE=01; 11 treated as M_NOP.
REQ-007 r0_addr / r1_addr  input  ADDR_W each  word address.
REQ-008 r0_wdata / r1_wdata  input  DATA_W each  write data.
REQ-009 r0_gnt / r1_gnt  output  1 each  command accepted this cycle (combinational).
REQ-010 r0_rdata / r1_rdata  output  DATA_W each  registered read data.
REQ-011 r0_rvalid / r1_rvalid  output  1 each  one-cycle pulse: rdata valid.
REQ-012 mem_write  output  1  write strobe to the shared RAM port.
REQ-013 mem_addr  output  ADDR_W  shared RAM address, used for both read and write.
REQ-014 mem_wdata  output  DATA_W  shared RAM write data.
REQ-015 mem_rdata  input  DATA_W  RAM data out; RAM registers it on the falling clock edge.

Function
REQ-016 A requester is active when its cmd is M_READ or M_WRITE; it holds cmd, addr and wdata stable until its gnt is high.
REQ-017 At most one gnt is high in any cycle; a gnt is never high for an inactive requester.
REQ-018 FSM states: IDLE, OWN0, OWN1, registered, with a hold counter and a last-served pointer.
REQ-019 IDLE, exactly one active: grant it this cycle; next state OWNn.
REQ-020 IDLE, both active: grant the requester not last served; next state OWNn.
REQ-021 OWNn, owner active, and (other inactive or hold count < MAX_HOLD): grant owner; hold count +1, saturating at MAX_HOLD.
REQ-022 OWNn, owner active, other active, hold count = MAX_HOLD: grant other; next state OWN(other); hold count = 1.
REQ-023 OWNn, owner inactive: behave as IDLE this cycle (grant per REQ-019/020 or none; next state IDLE if none).
REQ-024 Every state entry via a grant loads hold count = 1; last-served pointer = granted requester on every grant.
REQ-025 Granted cycle: mem_addr = granted addr; mem_wdata = granted wdata; mem_write = 1 only for M_WRITE.
REQ-026 No grant: mem_write = 0; mem_addr and mem_wdata hold the last granted values.
REQ-027 Read granted in cycle N: at the rising edge ending N, rdata of that requester <= mem_rdata and its rvalid = 1 for cycle N+1 only; latency is one cycle.
REQ-028 The other requester's rdata is unchanged and its rvalid is 0.
REQ-029 Back-to-back reads to one requester yield back-to-back rvalid pulses.
REQ-030 Write granted: no rvalid; no write data buffered beyond the grant cycle.
REQ-031 Hold count never exceeds MAX_HOLD; MAX_HOLD=1 yields strict alternation under contention.

Reset
REQ-032 Reset high at a rising edge: state = IDLE, hold count = 0, last-served = r1 (r0 wins the first tie), rvalid = 0, rdata = 0, last mem_addr/mem_wdata = 0.
REQ-033 In a reset cycle: no gnt and mem_write = 0.
REQ-034 A read granted the cycle before reset produces no rvalid.

Structure
REQ-035 Shared package mem_arb_pkg holds the M_NOP/M_READ/M_WRITE command encodings and the FSM state enum.
REQ-036 Single module with no sub-module; the RAM and its requesters are instantiated at top level.

Verification
REQ-037 Only r0 reads 0x05 (RAM[5]=0xABCD) -> r0_gnt same cycle; r0_rvalid=1 with r0_rdata=0xABCD next cycle; r1 outputs unchanged.
REQ-038 From reset, both write simultaneously (r0: 0x10<-0x1111, r1: 0x11<-0x2222) -> r0 granted first, then r1; RAM[0x10]=0x1111 and RAM[0x11]=0x2222.
REQ-039 r0 streams 10 reads while r1 holds one read, MAX_HOLD=4 -> r0 granted 4 cycles, then r1 once, then r0 resumes; never two gnts.
REQ-040 Read, write, read to 0x20 by r1 (write 0x5A5A) -> second read returns 0x5A5A.
REQ-041 Reset asserted the cycle after an r0 read grant -> no r0_rvalid; outputs at reset values; r0 wins the next tie.
REQ-042 cmd=11 from r0 with r1 idle -> no gnt and mem_write=0.
